nios_system_multi_timer: RTL



---
 rtl/nios_system_multi_timer_if.sv | 28 ++
 rtl/nios_system_multi_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nios_system_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// Carries the word-addressed register port plus the shared interrupt line.
interface nios_system_multi_timer_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/nios_system_multi_timer.sv
// Multi-channel interval timer: NUM_CH independent down-counters behind one Avalon-MM slave.
// Optional per-channel clock prescaler is built only when MULTI_TIMER_PRESCALE_EN is defined.
module nios_system_multi_timer #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios_system_multi_timer_if.slave      bus
);

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

    logic        w_wrStrobe;
    logic [1:0]  w_chSel;
    logic [2:0]  w_regSel;
    logic [15:0] w_chRead [NUM_CH];
    logic [NUM_CH-1:0] w_chIrq;
    logic [15:0] w_rdMux;
    logic [15:0] r_readdata;

    assign w_wrStrobe = bus.chipselect & ~bus.write_n;
    assign w_chSel    = bus.address[4:3];
    assign w_regSel   = bus.address[2:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        logic             w_chWr;
        logic             w_wrStatus;
        logic             w_wrCtrl;
        logic             w_wrPeriodL;
        logic             w_wrPeriodH;
        logic             w_wrSnap;
        logic             w_start;
        logic             w_stop;
        logic             w_tick;
        logic             w_zero;
        logic             w_event;
        logic             w_oneShotStop;
        logic [15:0]      w_rd;
        logic [CNT_W-1:0] r_period;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_snap;
        logic [3:0]       r_ctrl;
        logic             r_run;
        logic             r_to;
        logic             r_zeroDly;
        logic             r_forceReload;

        assign w_chWr        = w_wrStrobe && (w_chSel == 2'(g));
        assign w_wrStatus    = w_chWr && (w_regSel == 3'd0);
        assign w_wrCtrl      = w_chWr && (w_regSel == 3'd1);
        assign w_wrPeriodL   = w_chWr && (w_regSel == 3'd2);
        assign w_wrPeriodH   = w_chWr && (w_regSel == 3'd3);
        assign w_wrSnap      = w_chWr && ((w_regSel == 3'd4) || (w_regSel == 3'd5));
        assign w_start       = w_wrCtrl && bus.writedata[2];
        assign w_stop        = w_wrCtrl && bus.writedata[3];
        assign w_zero        = (r_cnt == '0);
        assign w_event       = w_zero && !r_zeroDly;
        assign w_oneShotStop = r_run && w_zero && !r_ctrl[1];

`ifdef MULTI_TIMER_PRESCALE_EN
        logic        w_wrPre;
        logic [15:0] r_pre;
        logic [15:0] r_psc;

        assign w_wrPre = w_chWr && (w_regSel == 3'd6);
        // >= rather than == so lowering PRE mid-count cannot strand the counter above it
        assign w_tick  = r_run && (r_psc >= r_pre);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pre <= '0;
                r_psc <= '0;
            end else begin
                if (w_wrPre) begin
                    r_pre <= bus.writedata;
                end
                if (w_start || r_forceReload) begin
                    r_psc <= '0;
                end else if (r_run) begin
                    r_psc <= w_tick ? 16'd0 : r_psc + 16'd1;
                end
            end
        end
`else
        assign w_tick = r_run;
`endif

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_period      <= RST_VAL;
                r_ctrl        <= '0;
                r_snap        <= '0;
                r_forceReload <= 1'b0;
            end else begin
                if (w_wrPeriodL) begin
                    r_period[15:0] <= bus.writedata;
                end
                if (w_wrPeriodH) begin
                    r_period[CNT_W-1:16] <= bus.writedata[CNT_W-17:0];
                end
                if (w_wrCtrl) begin
                    r_ctrl <= bus.writedata[3:0];
                end
                if (w_wrSnap) begin
                    r_snap <= r_cnt;
                end
                r_forceReload <= w_wrPeriodL || w_wrPeriodH;
            end
        end

        // One-shot holds at zero instead of reloading, so the expired count stays visible
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= RST_VAL;
            end else if (r_forceReload) begin
                r_cnt <= r_period;
            end else if (w_tick) begin
                if (!w_zero) begin
                    r_cnt <= r_cnt - 1'b1;
                end else if (r_ctrl[1]) begin
                    r_cnt <= r_period;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_run     <= 1'b0;
                r_to      <= 1'b0;
                r_zeroDly <= 1'b0;
            end else begin
                if (w_start) begin
                    r_run <= 1'b1;
                end else if (w_stop || r_forceReload || w_oneShotStop) begin
                    r_run <= 1'b0;
                end
                if (w_wrStatus) begin
                    r_to <= 1'b0;
                end else if (w_event) begin
                    r_to <= 1'b1;
                end
                r_zeroDly <= w_zero;
            end
        end

        always_comb begin
            w_rd = '0;
            case (w_regSel)
                3'd0: w_rd = {14'd0, r_run, r_to};
                3'd1: w_rd = {12'd0, r_ctrl};
                3'd2: w_rd = r_period[15:0];
                3'd3: w_rd = 16'(r_period[CNT_W-1:16]);
                3'd4: w_rd = r_snap[15:0];
                3'd5: w_rd = 16'(r_snap[CNT_W-1:16]);
`ifdef MULTI_TIMER_PRESCALE_EN
                3'd6: w_rd = r_pre;
`endif
                default: w_rd = '0;
            endcase
        end

        assign w_chRead[g] = w_rd;
        assign w_chIrq[g]  = r_to && r_ctrl[0];
    end

    // Unpopulated channel slots fall through to zero
    always_comb begin
        w_rdMux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_chSel == 2'(i)) begin
                w_rdMux = w_chRead[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdMux;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |w_chIrq;

endmodule
